// File: rtl/itcm_port_arbiter.sv
// ITCM single-port SRAM sequencer: boot auto-load, then fetch/AXI arbitration
// with fetch priority and a bounded AXI wait.
module itcm_port_arbiter #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           WORD_AW      = 13,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE    = '0,
  parameter int unsigned           LOAD_WORDS   = 8192,
  parameter int unsigned           AXI_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic                  o_load_busy,
  input  logic                  i_instr_req,
  input  logic [ADDR_WIDTH-1:0] i_instr_addr,
  output logic                  o_instr_gnt,
  output logic                  o_instr_rvalid,
  output logic [DATA_WIDTH-1:0] o_instr_rdata,
  input  logic                  i_axi_req,
  input  logic                  i_axi_wr,
  input  logic [ADDR_WIDTH-1:0] i_axi_addr,
  input  logic [3:0]            i_axi_be,
  input  logic [DATA_WIDTH-1:0] i_axi_wdata,
  output logic                  o_axi_gnt,
  output logic                  o_axi_rvalid,
  output logic [DATA_WIDTH-1:0] o_axi_rdata,
  output logic                  o_mem_ce,
  output logic                  o_mem_we,
  output logic [WORD_AW-1:0]    o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int unsigned WAIT_W = $clog2(AXI_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(AXI_MAX_WAIT);
  localparam logic [WORD_AW-1:0] LOAD_LAST = (LOAD_WORDS == 0) ? '0 : WORD_AW'(LOAD_WORDS - 1);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;
  localparam state_t RST_STATE = (LOAD_WORDS != 0) ? S_LOAD : S_RUN;

  state_t             r_state;
  logic [WORD_AW-1:0] r_load_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic               r_instr_rvalid;
  logic               r_axi_rvalid;

  logic               w_axi_win;
  logic               w_instr_win;
  logic [WORD_AW-1:0] w_instr_word;
  logic [WORD_AW-1:0] w_axi_word;

  // Upper byte-address bits beyond the SRAM size are intentionally dropped.
  assign w_instr_word = WORD_AW'((i_instr_addr - ITCM_BASE) >> 2);
  assign w_axi_word   = WORD_AW'((i_axi_addr - ITCM_BASE) >> 2);

  always_comb begin
    w_axi_win   = 1'b0;
    w_instr_win = 1'b0;
    o_mem_ce    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_be    = 4'h0;
    o_mem_wdata = '0;
    case (r_state)
      S_LOAD: begin
        if (i_load_valid) begin
          o_mem_ce    = 1'b1;
          o_mem_we    = 1'b1;
          o_mem_addr  = r_load_cnt;
          o_mem_be    = 4'hF;
          o_mem_wdata = i_load_data;
        end else begin
          o_mem_ce = 1'b0;
        end
      end
      S_RUN: begin
        // Fetch has priority until AXI has been denied AXI_MAX_WAIT cycles in a row.
        if (i_axi_req && (!i_instr_req || (r_wait_cnt == WAIT_MAX))) begin
          w_axi_win   = 1'b1;
          o_mem_ce    = 1'b1;
          o_mem_we    = i_axi_wr;
          o_mem_addr  = w_axi_word;
          o_mem_be    = i_axi_wr ? i_axi_be : 4'hF;
          o_mem_wdata = i_axi_wdata;
        end else if (i_instr_req) begin
          w_instr_win = 1'b1;
          o_mem_ce    = 1'b1;
          o_mem_addr  = w_instr_word;
          o_mem_be    = 4'hF;
        end else begin
          o_mem_ce = 1'b0;
        end
      end
      default: begin
        o_mem_ce = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= RST_STATE;
      r_load_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_instr_rvalid <= 1'b0;
      r_axi_rvalid   <= 1'b0;
    end else begin
      r_instr_rvalid <= w_instr_win;
      r_axi_rvalid   <= w_axi_win & ~i_axi_wr;
      if (i_axi_req && !w_axi_win) begin
        if (r_wait_cnt != WAIT_MAX) begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end else begin
          r_wait_cnt <= r_wait_cnt;
        end
      end else begin
        r_wait_cnt <= '0;
      end
      case (r_state)
        S_LOAD: begin
          if (i_load_valid) begin
            r_load_cnt <= r_load_cnt + WORD_AW'(1);
            if (r_load_cnt == LOAD_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_LOAD;
            end
          end else begin
            r_load_cnt <= r_load_cnt;
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= RST_STATE;
      endcase
    end
  end

  assign o_load_busy    = (r_state == S_LOAD);
  assign o_instr_gnt    = w_instr_win;
  assign o_axi_gnt      = w_axi_win;
  assign o_instr_rvalid = r_instr_rvalid;
  assign o_axi_rvalid   = r_axi_rvalid;
  // SRAM already supplies data one cycle after the read, so data passes straight through.
  assign o_instr_rdata  = i_mem_rdata;
  assign o_axi_rdata    = i_mem_rdata;

endmodule
